// File: rtl/btn_evt_pkg.sv
// Shared types and constants for the button event arbiter.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [7:0] PRESS_BASE_DEF   = 8'h30;
  localparam logic [7:0] RELEASE_BASE_DEF = 8'h61;
  localparam int         STB_CNT_W        = 4;

endpackage

// File: rtl/btn_event_arbiter_if.sv
// UART TX start handshake: arbiter is master, UART is slave.
interface btn_event_arbiter_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/btn_event_arbiter_debounce_ch.sv
// One button channel: 2-flop synchronizer, tick-sampled stable counter,
// debounced level and one-cycle edge pulses.
// Optional macro BTN_RELEASE_EVT_EN adds the release pulse output.
module btn_debounce_ch
  import btn_evt_pkg::*;
#(
  parameter int STABLE_TICKS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
`ifdef BTN_RELEASE_EVT_EN
  output logic rel_evt,
`endif
  output logic press
);

  localparam logic [STB_CNT_W-1:0] STB_MAX = STB_CNT_W'(STABLE_TICKS);

  logic [1:0]           sync_q;
  logic [STB_CNT_W-1:0] stb_cnt;

  // Synchronize the raw asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], btn_raw};
  end

  // Count consecutive disagreeing samples; toggle level once they reach STB_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= 1'b0;
      stb_cnt <= '0;
      press   <= 1'b0;
`ifdef BTN_RELEASE_EVT_EN
      rel_evt <= 1'b0;
`endif
    end else begin
      press <= 1'b0;
`ifdef BTN_RELEASE_EVT_EN
      rel_evt <= 1'b0;
`endif
      if (tick) begin
        if (sync_q[1] == level) begin
          stb_cnt <= '0;
        end else if (stb_cnt + 1'b1 == STB_MAX) begin
          level   <= ~level;
          stb_cnt <= '0;
          press   <= ~level;
`ifdef BTN_RELEASE_EVT_EN
          rel_evt <= level;
`endif
        end else begin
          stb_cnt <= stb_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Button debounce + round-robin event scheduler feeding one UART TX.
// Optional macro BTN_RELEASE_EVT_EN: release edges are queued and sent too.
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int         N_BTN        = 4,
  parameter int         TICK_DIV     = 12_500_000,
  parameter int         STABLE_TICKS = 2,
  parameter logic [7:0] PRESS_BASE   = PRESS_BASE_DEF,
  parameter logic [7:0] RELEASE_BASE = RELEASE_BASE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BTN-1:0]    btn_in,
  output logic [N_BTN-1:0]    btn_level,
  output logic                evt_overflow,
  btn_event_arbiter_if.master tx
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef BTN_RELEASE_EVT_EN
  localparam int REQ_N = 2 * N_BTN;
`else
  localparam int REQ_N = N_BTN;
`endif
  localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [N_BTN-1:0]  press_v, pending, grant_p;
  logic [REQ_N-1:0]  req, grant_v;
  logic [PTR_W-1:0]  rr_ptr, sel;
  logic              found, issue, ovf_hit;
  logic [7:0]        code;
  state_t            state;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Free-running sample tick shared by all channels.
  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

`ifdef BTN_RELEASE_EVT_EN
  logic [N_BTN-1:0] rel_v, rel_pending, grant_r;

  btn_debounce_ch #(.STABLE_TICKS(STABLE_TICKS)) u_ch [N_BTN-1:0] (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .btn_raw (btn_in),
    .level   (btn_level),
    .rel_evt (rel_v),
    .press   (press_v)
  );

  assign req     = {rel_pending, pending};
  assign grant_p = grant_v[N_BTN-1:0];
  assign grant_r = grant_v[REQ_N-1:N_BTN];
  assign ovf_hit = |(press_v & pending & ~grant_p) | |(rel_v & rel_pending & ~grant_r);

  // Release requests: same set/clear/overflow rules as presses.
  always_ff @(posedge clk) begin
    if (rst) rel_pending <= '0;
    else     rel_pending <= (rel_pending & ~grant_r) | rel_v;
  end
`else
  btn_debounce_ch #(.STABLE_TICKS(STABLE_TICKS)) u_ch [N_BTN-1:0] (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .btn_raw (btn_in),
    .level   (btn_level),
    .press   (press_v)
  );

  assign req     = pending;
  assign grant_p = grant_v;
  assign ovf_hit = |(press_v & pending & ~grant_p);
`endif

  // Press requests: an event on a bit being granted this cycle keeps it set.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~grant_p) | press_v;
  end

  // Sticky overflow: an event landed on a bit that was already waiting.
  always_ff @(posedge clk) begin
    if (rst)          evt_overflow <= 1'b0;
    else if (ovf_hit) evt_overflow <= 1'b1;
  end

  // First set request at or after rr_ptr, wrapping; lowest offset wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = REQ_N - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % REQ_N]) begin
        found = 1'b1;
        sel   = PTR_W'((int'(rr_ptr) + k) % REQ_N);
      end
    end
  end

  // Hold off while the UART is still busy, e.g. finishing a byte across a reset.
  assign issue   = (state == IDLE) && found && !tx.tx_busy;
  assign grant_v = issue ? (REQ_N'(1) << sel) : '0;

  // Byte code of the selected requester.
  always_comb begin
    code = PRESS_BASE + 8'(sel);
`ifdef BTN_RELEASE_EVT_EN
    if (int'(sel) >= N_BTN) code = RELEASE_BASE + 8'(int'(sel) - N_BTN);
`endif
  end

  // Grant FSM owning the TX start handshake; outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      tx.tx_start <= 1'b0;
      tx.tx_data  <= 8'h00;
    end else begin
      tx.tx_start <= 1'b0;
      case (state)
        IDLE: if (issue) begin
          tx.tx_data  <= code;
          tx.tx_start <= 1'b1;
          rr_ptr      <= PTR_W'((int'(sel) + 1) % REQ_N);
          state       <= WAIT_ACK;
        end
        WAIT_ACK:  if (tx.tx_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!tx.tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter (TICK_DIV=4, STABLE_TICKS=2, N_BTN=4).
// A negedge UART model raises tx_busy for busy_len cycles per start and logs bytes.
module tb_btn_event_arbiter;
  import btn_evt_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = '0;
  logic [3:0] btn_level;
  logic       evt_overflow;
  logic       uart_busy = 1'b0;
  logic       busy_stuck = 1'b0;
  int         busy_len = 5;
  int         bcnt = 0;
  int         start_cnt = 0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] byte_q[$];

  btn_event_arbiter_if bus();
  assign bus.tx_busy = uart_busy | busy_stuck;

  btn_event_arbiter #(.N_BTN(4), .TICK_DIV(4), .STABLE_TICKS(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .evt_overflow (evt_overflow),
    .tx           (bus.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tx_start) begin
      byte_q.push_back(bus.tx_data);
      start_cnt++;
      bcnt = busy_len;
    end else if (bcnt > 0) begin
      bcnt--;
    end
    uart_busy = (bcnt > 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_in = '0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    byte_q.delete();
    start_cnt = 0;
  endtask

  function automatic logic [31:0] qb(input int i);
    return (byte_q.size() > i) ? 32'(byte_q[i]) : 32'hFFFF;
  endfunction

  initial begin
    // Reset / idle
    cyc(3);
    chk("rst_start", 32'(bus.tx_start), 0);
    chk("rst_data", 32'(bus.tx_data), 0);
    chk("rst_level", 32'(btn_level), 0);
    chk("rst_ovf", 32'(evt_overflow), 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    cyc(200);
    chk("idle_starts", start_cnt, 0);

    // Single press on channel 2, long busy
    busy_len = 10;
    btn_in[2] = 1'b1;
    cyc(30);
    chk("sp_level", 32'(btn_level), 32'h4);
    cyc(30);
    chk("sp_starts", start_cnt, 1);
    chk("sp_byte", qb(0), 32'h32);
    chk("sp_hold", 32'(bus.tx_data), 32'h32);
    btn_in[2] = 1'b0;
    cyc(40);
`ifdef BTN_RELEASE_EVT_EN
    chk("sp_rel_starts", start_cnt, 2);
    chk("sp_rel_byte", qb(1), 32'h63);
`else
    chk("sp_rel_starts", start_cnt, 1);
`endif

    // Bounce: input flips once per tick period so consecutive samples disagree
    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn_in[0] = ~btn_in[0];
      cyc(4);
      chk("bounce_level", 32'(btn_level[0]), 0);
    end
    btn_in = '0;
    cyc(20);
    chk("bounce_starts", start_cnt, 0);

    // Round-robin: 0,1,3 together from rr_ptr=0
    do_reset();
    busy_len = 5;
    btn_in = 4'b1011;
    cyc(60);
    chk("rr_n", 32'(byte_q.size()), 3);
    chk("rr_b0", qb(0), 32'h30);
    chk("rr_b1", qb(1), 32'h31);
    chk("rr_b2", qb(2), 32'h33);
    btn_in = '0;
    cyc(40);
    do_reset();
    btn_in = 4'b1001;
    cyc(40);
    chk("rr2_n", 32'(byte_q.size()), 2);
    chk("rr2_b0", qb(0), 32'h30);
    chk("rr2_b1", qb(1), 32'h33);
    btn_in = '0;
    cyc(40);

    // Overflow with busy stuck high
    do_reset();
    busy_stuck = 1'b1;
    btn_in[1] = 1'b1;
    cyc(30);
    btn_in[1] = 1'b0;
    cyc(30);
    chk("ovf_pre", 32'(evt_overflow), 0);
    btn_in[1] = 1'b1;
    cyc(30);
    chk("ovf_flag", 32'(evt_overflow), 1);
    chk("ovf_pend", 32'(dut.pending[1]), 1);
    chk("ovf_nostart", start_cnt, 0);
    busy_stuck = 1'b0;
    cyc(60);
`ifdef BTN_RELEASE_EVT_EN
    chk("ovf_n", 32'(byte_q.size()), 2);
    chk("ovf_b1", qb(1), 32'h62);
`else
    chk("ovf_n", 32'(byte_q.size()), 1);
`endif
    chk("ovf_b0", qb(0), 32'h31);
    chk("ovf_sticky", 32'(evt_overflow), 1);
    btn_in[1] = 1'b0;
    cyc(40);

    // Reset mid-transfer with pending[3] set
    do_reset();
    busy_len = 60;
    btn_in[3] = 1'b1;
    cyc(20);
    chk("mid_start", start_cnt, 1);
    btn_in[3] = 1'b0;
    cyc(20);
    btn_in[3] = 1'b1;
    cyc(20);
    chk("mid_state", 32'(dut.state), 32'(WAIT_DONE));
    chk("mid_pend", 32'(dut.pending[3]), 1);
    btn_in[3] = 1'b0;
    rst = 1'b1;
    cyc(2);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    chk("mid_rst_pend", 32'(dut.pending), 0);
    rst = 1'b0;
    start_cnt = 0;
    cyc(100);
    chk("mid_nostart", start_cnt, 0);

    // Press then release channel 2
    do_reset();
    busy_len = 5;
    btn_in[2] = 1'b1;
    cyc(40);
    btn_in[2] = 1'b0;
    cyc(40);
    chk("pr_b0", qb(0), 32'h32);
`ifdef BTN_RELEASE_EVT_EN
    chk("pr_n", 32'(byte_q.size()), 2);
    chk("pr_b1", qb(1), 32'h63);
`else
    chk("pr_n", 32'(byte_q.size()), 1);
`endif
    chk("pr_level", 32'(btn_level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
